// File: rtl/i2s_pkg.sv
// Shared definitions for the i2s_tx sample scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2s_pkg;

    // Default sample width; matches the i2s_tx serializer.
    localparam int I2S_AUDIO_DW = 32;

    // Scheduler states: IDLE/PRIME hold i2s_tx in reset, RUN/FLUSH let it shift.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } sched_state_e;

endpackage

// File: rtl/i2s_sample_fifo.sv
// Synchronous FIFO holding packed {left,right} stereo samples.
// Latency: a pushed entry is visible at the head from the following cycle (no bypass).
// Backpressure: push ignored when full, pop ignored when empty; full/empty/level are registered.
module i2s_sample_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            push_dat,
    input  logic                     pop,
    output logic [DW-1:0]            pop_dat,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign pop_dat = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointer and occupancy update; simultaneous push and pop keep the level.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Control state; reset empties the FIFO without touching storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Sample storage write port.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/i2s_tx_scheduler.sv
// Feeds i2s_tx: queues stereo samples, primes, then reloads left/right_chan on each capture edge.
// Latency: first capture prescaler cycles after tx_rst falls, then one sample every 2*prescaler cycles.
// Backpressure: s_ready drops while the FIFO is full; an empty FIFO at capture sends 0/0 and counts an underrun.
module i2s_tx_scheduler
    import i2s_pkg::*;
#(
    parameter int AUDIO_DW    = I2S_AUDIO_DW,
    parameter int FIFO_DEPTH  = 4,
    parameter int PRIME_LEVEL = 2,
    parameter int CNT_W       = 16
) (
    input  logic                          sclk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [AUDIO_DW-1:0]           prescaler,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [AUDIO_DW-1:0]           s_left,
    input  logic [AUDIO_DW-1:0]           s_right,
    output logic [AUDIO_DW-1:0]           left_chan,
    output logic [AUDIO_DW-1:0]           right_chan,
    output logic                          tx_rst,
    output logic                          busy,
    output logic                          underrun,
    output logic [CNT_W-1:0]              underrun_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);

    sched_state_e              state_q, state_d;
    logic                      tx_rst_q, tx_rst_d;
    logic [AUDIO_DW-1:0]       left_q, left_d;
    logic [AUDIO_DW-1:0]       right_q, right_d;
    logic                      underrun_q, underrun_d;
    logic [CNT_W-1:0]          ucnt_q, ucnt_d;
    logic [AUDIO_DW-1:0]       cnt_q, cnt_d;
    logic                      lr_q, lr_d;

    logic                      fifo_push;
    logic                      fifo_pop;
    logic [2*AUDIO_DW-1:0]     head_dat;
    logic [LW-1:0]             level;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      cap;

    assign s_ready   = !fifo_full;
    assign fifo_push = s_valid && s_ready;

    // Capture edge of i2s_tx: end of the right-channel slot of the mirrored frame.
    assign cap = !tx_rst_q && (cnt_q == prescaler) && lr_q;

    i2s_sample_fifo #(
        .DW    (2 * AUDIO_DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (sclk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat ({s_left, s_right}),
        .pop      (fifo_pop),
        .pop_dat  (head_dat),
        .level    (level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Next-state logic: sequencing, channel reloads, underrun bookkeeping and frame mirror.
    always_comb begin
        state_d    = state_q;
        left_d     = left_q;
        right_d    = right_q;
        underrun_d = 1'b0;
        ucnt_d     = ucnt_q;
        fifo_pop   = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (level >= PRIME_LVL) begin
                    fifo_pop          = 1'b1;
                    {left_d, right_d} = head_dat;
                    state_d           = RUN;
                end
            end
            RUN: begin
                if (cap) begin
                    if (!en) begin
                        // Stop: the in-flight sample finishes, silence follows.
                        left_d  = '0;
                        right_d = '0;
                        state_d = FLUSH;
                    end else if (fifo_empty) begin
                        left_d     = '0;
                        right_d    = '0;
                        underrun_d = 1'b1;
                        if (ucnt_q != {CNT_W{1'b1}}) begin
                            ucnt_d = ucnt_q + CNT_W'(1);
                        end
                    end else begin
                        fifo_pop          = 1'b1;
                        {left_d, right_d} = head_dat;
                    end
                end
            end
            FLUSH: begin
                if (cap) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // i2s_tx is held in reset whenever the next state does not stream.
        tx_rst_d = (state_d == IDLE) || (state_d == PRIME);

        // Mirror of the i2s_tx slot counter.
        if (tx_rst_q) begin
            cnt_d = AUDIO_DW'(1);
            lr_d  = 1'b1;
        end else begin
            cnt_d = (cnt_q >= prescaler) ? AUDIO_DW'(1) : cnt_q + AUDIO_DW'(1);
            lr_d  = (cnt_q == prescaler) ? !lr_q : lr_q;
        end
    end

    // Scheduler state and registered outputs.
    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_rst_q   <= 1'b1;
            left_q     <= '0;
            right_q    <= '0;
            underrun_q <= 1'b0;
            ucnt_q     <= '0;
            cnt_q      <= AUDIO_DW'(1);
            lr_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            tx_rst_q   <= tx_rst_d;
            left_q     <= left_d;
            right_q    <= right_d;
            underrun_q <= underrun_d;
            ucnt_q     <= ucnt_d;
            cnt_q      <= cnt_d;
            lr_q       <= lr_d;
        end
    end

    assign left_chan    = left_q;
    assign right_chan   = right_q;
    assign tx_rst       = tx_rst_q;
    assign busy         = (state_q != IDLE);
    assign underrun     = underrun_q;
    assign underrun_cnt = ucnt_q;
    assign fifo_level   = level;

endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// Directed bench for i2s_tx_scheduler: per-cycle vector table plus hand sequences.
// Latency: outputs sampled on the falling edge after each rising edge.
// Backpressure: producer valid is driven regardless of s_ready to exercise hold-off.
module tb_i2s_tx_scheduler;

    localparam int DW = 32;

    logic          sclk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [DW-1:0] prescaler = 32'd4;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_left = '0;
    logic [DW-1:0] s_right = '0;
    logic [DW-1:0] left_chan;
    logic [DW-1:0] right_chan;
    logic          tx_rst;
    logic          busy;
    logic          underrun;
    logic [1:0]    underrun_cnt;
    logic [2:0]    fifo_level;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 sclk = ~sclk;

    i2s_tx_scheduler #(
        .AUDIO_DW    (DW),
        .FIFO_DEPTH  (4),
        .PRIME_LEVEL (2),
        .CNT_W       (2)
    ) dut (
        .sclk         (sclk),
        .rst          (rst),
        .en           (en),
        .prescaler    (prescaler),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_left       (s_left),
        .s_right      (s_right),
        .left_chan    (left_chan),
        .right_chan   (right_chan),
        .tx_rst       (tx_rst),
        .busy         (busy),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt),
        .fifo_level   (fifo_level)
    );

    typedef struct packed {
        logic          rdy;
        logic [2:0]    lvl;
        logic          txr;
        logic          bsy;
        logic [DW-1:0] lc;
        logic [DW-1:0] rc;
        logic          ur;
        logic [1:0]    uc;
    } out_t;

    typedef struct {
        logic          rst;
        logic          en;
        logic          vld;
        logic [DW-1:0] sl;
        logic [DW-1:0] sr;
        out_t          exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic e_in, input logic v,
                       input logic [DW-1:0] sl, input logic [DW-1:0] sr,
                       input out_t e, input int n);
        vec_t row;
        row.rst = r; row.en = e_in; row.vld = v;
        row.sl = sl; row.sr = sr; row.exp = e;
        repeat (n) tbl.push_back(row);
    endtask

    task automatic check(input string name, input out_t e);
        out_t a;
        a = '{rdy: s_ready, lvl: fifo_level, txr: tx_rst, bsy: busy,
              lc: left_chan, rc: right_chan, ur: underrun, uc: underrun_cnt};
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got rdy=%b lvl=%0d txr=%b bsy=%b l=%h r=%h ur=%b uc=%0d; want rdy=%b lvl=%0d txr=%b bsy=%b l=%h r=%h ur=%b uc=%0d",
                     name, a.rdy, a.lvl, a.txr, a.bsy, a.lc, a.rc, a.ur, a.uc,
                     e.rdy, e.lvl, e.txr, e.bsy, e.lc, e.rc, e.ur, e.uc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sclk);
            @(negedge sclk);
        end
    endtask

    out_t e;

    initial begin
        // Cycle table: fill while IDLE, overflow hold-off, prime, 8-cycle caps, underruns.
        e = '{rdy: 1'b1, lvl: 3'd0, txr: 1'b1, bsy: 1'b0, lc: '0, rc: '0, ur: 1'b0, uc: 2'd0};
        add(1, 0, 0, 0, 0, e, 1);                               // reset state
        e.lvl = 3'd1; add(0, 0, 1, 32'hA1, 32'hB1, e, 1);
        e.lvl = 3'd2; add(0, 0, 1, 32'hA2, 32'hB2, e, 1);
        e.lvl = 3'd3; add(0, 0, 1, 32'hA3, 32'hB3, e, 1);
        e.lvl = 3'd4; e.rdy = 1'b0; add(0, 0, 1, 32'hA4, 32'hB4, e, 1);
        add(0, 0, 1, 32'hA5, 32'hB5, e, 1);                     // fifth sample held off
        e.bsy = 1'b1; add(0, 1, 0, 0, 0, e, 1);                 // PRIME
        e.txr = 1'b0; e.lvl = 3'd3; e.rdy = 1'b1;
        e.lc = 32'hA1; e.rc = 32'hB1; add(0, 1, 0, 0, 0, e, 4); // RUN, first cap 4 later
        e.lc = 32'hA2; e.rc = 32'hB2; e.lvl = 3'd2; add(0, 1, 0, 0, 0, e, 8);
        e.lc = 32'hA3; e.rc = 32'hB3; e.lvl = 3'd1; add(0, 1, 0, 0, 0, e, 8);
        e.lc = 32'hA4; e.rc = 32'hB4; e.lvl = 3'd0; add(0, 1, 0, 0, 0, e, 8);
        e.lc = '0; e.rc = '0; e.ur = 1'b1; e.uc = 2'd1; add(0, 1, 0, 0, 0, e, 1);
        e.ur = 1'b0; add(0, 1, 0, 0, 0, e, 7);
        e.ur = 1'b1; e.uc = 2'd2; add(0, 1, 0, 0, 0, e, 1);
        e.ur = 1'b0; add(0, 1, 0, 0, 0, e, 7);
        e.ur = 1'b1; e.uc = 2'd3; add(0, 1, 0, 0, 0, e, 1);
        e.ur = 1'b0; add(0, 1, 0, 0, 0, e, 7);
        e.ur = 1'b1; add(0, 1, 0, 0, 0, e, 1);                  // counter saturated
        e.ur = 1'b0; add(0, 1, 0, 0, 0, e, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; en = tbl[i].en; s_valid = tbl[i].vld;
            s_left = tbl[i].sl; s_right = tbl[i].sr;
            step(1);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Refill while running, then stop mid-frame and flush to IDLE.
        s_valid = 1'b1; s_left = 32'hC1; s_right = 32'hD1; step(1);
        s_left = 32'hC2; s_right = 32'hD2; step(1);
        s_valid = 1'b0; step(4);
        e.lvl = 3'd2; check("pre_cap", e);
        step(1);
        e.lvl = 3'd1; e.lc = 32'hC1; e.rc = 32'hD1; check("refill_cap", e);
        step(3); en = 1'b0; step(4);
        check("en_low_hold", e);
        step(1);
        e.lc = '0; e.rc = '0; check("flush_zero", e);
        step(7);
        check("flush_hold", e);
        step(1);
        e.txr = 1'b1; e.bsy = 1'b0; check("flush_idle", e);

        // Restart with one queued entry: PRIME waits, pushed sample not usable that edge.
        en = 1'b1; step(1);
        e.bsy = 1'b1; check("prime_enter", e);
        step(3);
        check("prime_wait", e);
        s_valid = 1'b1; s_left = 32'hC3; s_right = 32'hD3; step(1);
        s_valid = 1'b0;
        e.lvl = 3'd2; check("prime_nobypass", e);
        step(1);
        e.lvl = 3'd1; e.txr = 1'b0; e.lc = 32'hC2; e.rc = 32'hD2; check("prime_start", e);

        // Reset while running.
        rst = 1'b1; step(1); rst = 1'b0;
        e = '{rdy: 1'b1, lvl: 3'd0, txr: 1'b1, bsy: 1'b0, lc: '0, rc: '0, ur: 1'b0, uc: 2'd0};
        check("reset_run", e);

        // Drop en while priming below threshold.
        s_valid = 1'b1; s_left = 32'hE1; s_right = 32'hF1; en = 1'b1; step(1);
        s_valid = 1'b0;
        e.lvl = 3'd1; e.bsy = 1'b1; check("d_prime", e);
        step(1);
        check("d_stay", e);
        en = 1'b0; step(1);
        e.bsy = 1'b0; check("d_idle", e);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
